// File: rtl/opc_bank_arbiter.sv
// Arbitrates operand-collector source-operand reads onto GPR read banks.
// Starving requesters get first pick, then round-robin from each bank's pointer.
module opc_bank_arbiter #(
   parameter int NUM_REQS     = 4,
   parameter int NUM_SRCS     = 3,
   parameter int NUM_BANKS    = 4,
   parameter int ADDR_W       = 8,
   parameter int STARVE_LIMIT = 7,
   localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
   localparam int RW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
   localparam int SW = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1,
   localparam int NS = NUM_REQS * NUM_SRCS
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NS-1:0]               req_valid,
   input  logic [NS*BW-1:0]            req_bank,
   input  logic [NS*ADDR_W-1:0]        req_addr,
   output logic [NS-1:0]               req_ready,
   output logic [NUM_BANKS-1:0]        bank_valid,
   output logic [NUM_BANKS*ADDR_W-1:0] bank_addr,
   output logic [NUM_BANKS*RW-1:0]     bank_req,
   output logic [NUM_BANKS*SW-1:0]     bank_opd,
   input  logic [NUM_BANKS-1:0]        bank_ready,
   output logic [31:0]                 perf_stalls
);
   localparam int CW = 8;

   logic [NUM_BANKS-1:0] bank_open;
   logic [NUM_BANKS-1:0] bank_hit;
   logic [RW-1:0]        win_req  [NUM_BANKS];
   logic [SW-1:0]        win_opd  [NUM_BANKS];
   logic [ADDR_W-1:0]    win_addr [NUM_BANKS];
   logic [RW-1:0]        ptr      [NUM_BANKS];
   logic [CW-1:0]        wait_cnt [NUM_REQS];
   logic [NUM_REQS-1:0]  starving;
   logic [NUM_REQS-1:0]  any_valid;
   logic [NUM_REQS-1:0]  any_grant;
   logic                 stall_cycle;

   function automatic int rot(input logic [RW-1:0] base, input int k);
      return (int'(base) + k) % NUM_REQS;
   endfunction

   function automatic int slot_idx(input logic [RW-1:0] base, input int k, input int s);
      return rot(base, k) * NUM_SRCS + s;
   endfunction

   always_comb begin
      starving = '0;
      for (int r = 0; r < NUM_REQS; r++) begin
         starving[r] = (wait_cnt[r] == CW'(STARVE_LIMIT));
      end
   end

   // Pass 0 only considers starving requesters, pass 1 everyone; the first hit wins.
   always_comb begin
      bank_open = '0;
      bank_hit  = '0;
      req_ready = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         win_req[b]  = '0;
         win_opd[b]  = '0;
         win_addr[b] = '0;
      end
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_open[b] = ~bank_valid[b] | bank_ready[b];
         if (!reset && bank_open[b]) begin
            for (int pass = 0; pass < 2; pass++) begin
               for (int k = 0; k < NUM_REQS; k++) begin
                  if (!bank_hit[b] && (pass == 1 || starving[rot(ptr[b], k)])) begin
                     for (int s = 0; s < NUM_SRCS; s++) begin
                        if (!bank_hit[b] && req_valid[slot_idx(ptr[b], k, s)] &&
                            req_bank[slot_idx(ptr[b], k, s)*BW +: BW] == BW'(b)) begin
                           bank_hit[b] = 1'b1;
                           win_req[b]  = RW'(rot(ptr[b], k));
                           win_opd[b]  = SW'(s);
                           win_addr[b] = req_addr[slot_idx(ptr[b], k, s)*ADDR_W +: ADDR_W];
                           req_ready[slot_idx(ptr[b], k, s)] = 1'b1;
                        end
                     end
                  end
               end
            end
         end
      end
   end

   always_comb begin
      any_valid = '0;
      any_grant = '0;
      for (int r = 0; r < NUM_REQS; r++) begin
         any_valid[r] = |req_valid[r*NUM_SRCS +: NUM_SRCS];
         any_grant[r] = |req_ready[r*NUM_SRCS +: NUM_SRCS];
      end
   end

   assign stall_cycle = |(req_valid & ~req_ready);

   // A closed bank keeps its outputs; an open bank reloads from this cycle's winner.
   always_ff @(posedge clk) begin
      if (reset) begin
         bank_valid  <= '0;
         bank_addr   <= '0;
         bank_req    <= '0;
         bank_opd    <= '0;
         perf_stalls <= '0;
         for (int b = 0; b < NUM_BANKS; b++) ptr[b] <= '0;
         for (int r = 0; r < NUM_REQS; r++) wait_cnt[r] <= '0;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_open[b]) begin
               bank_valid[b] <= bank_hit[b];
               if (bank_hit[b]) begin
                  bank_addr[b*ADDR_W +: ADDR_W] <= win_addr[b];
                  bank_req[b*RW +: RW]          <= win_req[b];
                  bank_opd[b*SW +: SW]          <= win_opd[b];
                  ptr[b] <= RW'((int'(win_req[b]) + 1) % NUM_REQS);
               end
            end
         end
         for (int r = 0; r < NUM_REQS; r++) begin
            if (any_valid[r] && !any_grant[r]) begin
               if (!starving[r]) wait_cnt[r] <= wait_cnt[r] + CW'(1);
            end else begin
               wait_cnt[r] <= '0;
            end
         end
         if (stall_cycle) perf_stalls <= perf_stalls + 32'd1;
      end
   end

endmodule

// File: doc/opc_bank_arbiter.md
OPC_BANK_ARBITER -- requirements
Module: opc_bank_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, meaning operand-collector requesters sharing the GPR banks.
REQ-002 SHALL have parameter NUM_SRCS, default 3, meaning source-operand request slots per requester.
REQ-003 SHALL have parameter NUM_BANKS, default 4, meaning GPR read banks (power of 2, ≥1).
REQ-004 SHALL have parameter ADDR_W, default 8, meaning bank read address width.
REQ-005 SHALL have parameter STARVE_LIMIT, default 7, meaning wait cycles before priority boost (1..255).
REQ-006 SHALL have port clk, input, 1, the clock.
REQ-007 SHALL have port reset, input, 1, the reset: synchronous, active-high, clock clk.
REQ-008 SHALL have port req_valid, input, NUM_REQS*NUM_SRCS, per-slot read request.
REQ-009 SHALL have port req_bank, input, NUM_REQS*NUM_SRCS*clog2(NUM_BANKS) (min 1), target bank per slot.
REQ-010 SHALL have port req_addr, input, NUM_REQS*NUM_SRCS*ADDR_W, bank address per slot.
REQ-011 SHALL have port req_ready, output, NUM_REQS*NUM_SRCS, per-slot grant (combinational).
REQ-012 SHALL have port bank_valid, output, NUM_BANKS, registered bank read strobe.
REQ-013 SHALL have port bank_addr, output, NUM_BANKS*ADDR_W, registered read address.
REQ-014 SHALL have port bank_req, output, NUM_BANKS*clog2(NUM_REQS) (min 1), granted requester id.
REQ-015 SHALL have port bank_opd, output, NUM_BANKS*clog2(NUM_SRCS), granted slot index.
REQ-016 SHALL have port bank_ready, input, NUM_BANKS, bank accepts the registered request.
REQ-017 SHALL have port perf_stalls, output, 32, count of conflict cycles.

Function
REQ-018 SHALL treat bank b as open when ~bank_valid[b] || bank_ready[b]; closed banks grant nothing.
REQ-019 SHALL grant at most one slot per open bank per cycle, and req_ready[r][s] SHALL be 1 only for granted slots.
REQ-020 SHALL require requesters to hold valid/bank/addr stable until granted; grant = valid && ready same cycle.
REQ-021 SHALL order candidates per bank: starving requesters first, then others; within each group round-robin from ptr[b]; within one requester lowest slot index first.
REQ-022 SHALL update ptr[b] to (granted requester + 1) mod NUM_REQS on a grant; otherwise hold.
REQ-023 SHALL load bank_valid/addr/req/opd on the clock edge after the grant (1-cycle latency); an open bank with no grant SHALL load bank_valid=0.
REQ-024 SHALL hold bank outputs unchanged while bank_valid[b] && ~bank_ready[b].
REQ-025 SHALL keep per-requester wait counter: +1 (saturating at STARVE_LIMIT) on cycles with ≥1 valid slot and zero grants; clear on any grant or no valid slot.
REQ-026 SHALL consider requester starving when its counter equals STARVE_LIMIT.
REQ-027 SHALL increment perf_stalls (wrapping) on each cycle with ≥1 valid slot not granted.
REQ-028 SHALL grant a requester multiple slots in one cycle when they target different banks.
REQ-029 SHALL ignore req_bank/req_addr of invalid slots entirely.

Reset
REQ-030 SHALL on reset clear bank_valid, bank_addr, bank_req, bank_opd, all ptr[b], all wait counters and perf_stalls to 0.
REQ-031 SHALL drive req_ready=0 during the reset cycle; requests pending across reset are re-arbitrated from ptr=0.

Verification
REQ-032 SHALL verify: r0 slots 0,1,2 -> banks 0,1,2, bank_ready=all 1 -> req_ready[0]=3'b111 same cycle; next cycle bank_valid=4'b0111, bank_opd={2,1,0}.
REQ-033 SHALL verify: r0..r3 slot0 all -> bank 1, held -> grants r0,r1,r2,r3,r0 on consecutive cycles; perf_stalls=4 after 4 cycles.
REQ-034 SHALL verify: r0 slots 0 and 2 -> bank 3 -> slot0 granted cycle N, slot2 granted cycle N+1.
REQ-035 SHALL verify: bank_ready[2]=0 for 3 cycles with bank_valid[2]=1 -> outputs for bank 2 frozen, no grants to bank 2, other banks unaffected.
REQ-036 SHALL verify: STARVE_LIMIT=2, r1 denied 2 cycles via closed bank, ptr favours r2 -> on bank reopen r1 granted before r2, counter returns 0.
REQ-037 SHALL verify: reset asserted while bank_valid=4'b1111 -> next cycle bank_valid=0, ptr=0, perf_stalls=0, first grant after release goes to r0.
